// File: rtl/spi_transfer_ctrl.sv
// SPI command decoder: burst BRAM channel writes/reads, processor launch,
// result readback, status byte, channel-range checking and chip-select abort.
module spi_transfer_ctrl #(
    parameter int ADDR_W = 17,
    parameter int PIXELS = 76800,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2,
    parameter int RES_W  = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_rx_valid,
    input  logic [7:0]        spi_rx_byte,
    output logic [7:0]        spi_tx_byte,
    input  logic              spi_cs_n,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [CH_W-1:0]   bram_channel,
    output logic              bram_we,
    output logic [7:0]        bram_wdata,
    input  logic [7:0]        bram_rdata,
    output logic              proc_active,
    input  logic              proc_done,
    input  logic [RES_W-1:0]  proc_result,
    output logic [2:0]        state,
    output logic              err
);

    localparam int RES_BYTES = (RES_W + 7) / 8;
    localparam int CNT_MAX   = (PIXELS > RES_BYTES) ? PIXELS : RES_BYTES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_PROC   = 8'h03;
    localparam logic [7:0] CMD_RESULT = 8'h04;
    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_CLEAR  = 8'h06;
    localparam logic [7:0] BUSY_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_CH = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_PROC   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t             state_reg, state_next;
    logic               mode_wr_reg, mode_wr_next;
    logic               err_reg, err_next;
    logic [CH_W-1:0]    channel_reg, channel_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               we_reg, we_next;
    logic [7:0]         wdata_reg, wdata_next;
    logic [1:0]         rd_pipe_reg, rd_pipe_next;
    logic [7:0]         rd_byte_reg, rd_byte_next;
    logic [RES_W-1:0]   result_reg, result_next;

    logic [RES_BYTES*8-1:0] result_padded;
    logic [7:0]             result_bytes [RES_BYTES];
    logic [7:0]             res_byte;
    logic [7:0]             status_byte;

    assign result_padded = (RES_BYTES*8)'(result_reg);

    for (genvar gi = 0; gi < RES_BYTES; gi++) begin : g_res_bytes
        assign result_bytes[gi] = result_padded[gi*8 +: 8];
    end

    always_comb begin
        res_byte = 8'h00;
        for (int i = 0; i < RES_BYTES; i++) begin
            if (cnt_reg == CNT_W'(i)) res_byte = result_bytes[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            mode_wr_reg <= 1'b0;
            err_reg     <= 1'b0;
            channel_reg <= '0;
            addr_reg    <= '0;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            wdata_reg   <= 8'h00;
            rd_pipe_reg <= 2'b00;
            rd_byte_reg <= 8'h00;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            mode_wr_reg <= mode_wr_next;
            err_reg     <= err_next;
            channel_reg <= channel_next;
            addr_reg    <= addr_next;
            cnt_reg     <= cnt_next;
            we_reg      <= we_next;
            wdata_reg   <= wdata_next;
            rd_pipe_reg <= rd_pipe_next;
            rd_byte_reg <= rd_byte_next;
            result_reg  <= result_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mode_wr_next = mode_wr_reg;
        err_next     = err_reg;
        channel_next = channel_reg;
        addr_next    = addr_reg;
        cnt_next     = cnt_reg;
        we_next      = 1'b0;
        wdata_next   = wdata_reg;
        rd_pipe_next = {rd_pipe_reg[0], 1'b0};
        rd_byte_next = rd_byte_reg;
        result_next  = result_reg;

        // Address advances the cycle after the write strobe, so the strobe
        // sees the address it was issued for; a finished burst rewinds to 0.
        if (we_reg) begin
            addr_next = (state_reg == S_WRITE) ? addr_reg + ADDR_W'(1) : '0;
        end

        // Read data arrives two edges after the address changes; the address
        // stops at the last pixel so the BRAM is never read past the image.
        if (rd_pipe_reg[1] && state_reg == S_READ) begin
            rd_byte_next = bram_rdata;
            if (addr_reg != ADDR_W'(PIXELS - 1)) addr_next = addr_reg + ADDR_W'(1);
        end

        case (state_reg)
            S_IDLE: begin
                if (spi_rx_valid) begin
                    case (spi_rx_byte)
                        CMD_WRITE:  begin state_next = S_GET_CH; mode_wr_next = 1'b1; end
                        CMD_READ:   begin state_next = S_GET_CH; mode_wr_next = 1'b0; end
                        CMD_PROC:   state_next = S_PROC;
                        CMD_RESULT: begin state_next = S_RESULT; cnt_next = '0; end
                        CMD_STATUS: ;
                        CMD_CLEAR:  err_next = 1'b0;
                        default:    err_next = 1'b1;
                    endcase
                end
            end
            S_GET_CH: begin
                if (spi_rx_valid) begin
                    if (spi_rx_byte < 8'(NUM_CH)) begin
                        channel_next = spi_rx_byte[CH_W-1:0];
                        addr_next    = '0;
                        cnt_next     = '0;
                        if (mode_wr_reg) begin
                            state_next = S_WRITE;
                        end else begin
                            state_next      = S_READ;
                            rd_pipe_next[0] = 1'b1;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (spi_rx_valid) begin
                    we_next    = 1'b1;
                    wdata_next = spi_rx_byte;
                    if (cnt_reg == CNT_W'(PIXELS - 1)) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_READ: begin
                if (spi_rx_valid) begin
                    if (cnt_reg == CNT_W'(PIXELS - 1)) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                        addr_next  = '0;
                    end else begin
                        cnt_next        = cnt_reg + CNT_W'(1);
                        rd_pipe_next[0] = 1'b1;
                    end
                end
            end
            S_PROC: begin
                if (proc_done) begin
                    result_next = proc_result;
                    state_next  = S_IDLE;
                end
            end
            S_RESULT: begin
                if (spi_rx_valid) begin
                    if (cnt_reg == CNT_W'(RES_BYTES - 1)) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Deselect abandons any transfer except processing, which must finish.
        if (spi_cs_n && state_reg != S_IDLE && state_reg != S_PROC) begin
            state_next   = S_IDLE;
            addr_next    = '0;
            cnt_next     = '0;
            rd_pipe_next = 2'b00;
        end
    end

    assign proc_active  = (state_reg == S_PROC);
    assign status_byte  = {proc_active, err_reg, 3'b000, state_reg};
    assign state        = state_reg;
    assign err          = err_reg;
    assign bram_addr    = addr_reg;
    assign bram_channel = channel_reg;
    assign bram_we      = we_reg;
    assign bram_wdata   = wdata_reg;

    always_comb begin
        case (state_reg)
            S_READ:   spi_tx_byte = rd_byte_reg;
            S_PROC:   spi_tx_byte = BUSY_BYTE;
            S_RESULT: spi_tx_byte = res_byte;
            default:  spi_tx_byte = status_byte;
        endcase
    end

endmodule
